// File: rtl/pe_dot_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : pe_dot_accumulator
// Purpose  : Accumulates signed adder-tree dot results over first/last
//            delimited groups. The control sideband enters at tree input and
//            is delayed TREE_LATENCY cycles to line up with i_dot. Finished
//            sums are queued in a 2-entry buffer drained by valid/ready.
// Ports    : clock, reset           - clock, synchronous active-high reset
//            i_valid/i_first/i_last - control, sampled at tree input
//            i_dot                  - tree result, TREE_LATENCY cycles later
//            o_valid/o_data/i_ready - output handshake (buffer head)
//            o_full                 - buffer holds 2 entries
//            o_in_group             - aligned group currently open
//            o_overflow             - sticky, a finished sum was dropped
//            o_sat                  - sticky saturation flag (option only)
// Option   : PE_ACCUM_SAT_EN - saturating accumulate and the o_sat port.
// Revision : 1.0 - initial release
// ============================================================================
module pe_dot_accumulator #(
  parameter int DOT_OUTPUT_WIDTH = 24,
  parameter int ACCUM_WIDTH      = 32,
  parameter int TREE_LATENCY     = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        i_valid,
  input  logic                        i_first,
  input  logic                        i_last,
  input  logic [DOT_OUTPUT_WIDTH-1:0] i_dot,
  output logic                        o_valid,
  output logic [ACCUM_WIDTH-1:0]      o_data,
  input  logic                        i_ready,
  output logic                        o_full,
  output logic                        o_in_group,
`ifdef PE_ACCUM_SAT_EN
  output logic                        o_sat,
`endif
  output logic                        o_overflow
);

  generate
    if (ACCUM_WIDTH < DOT_OUTPUT_WIDTH) begin : g_width_check
      $fatal(1, "ACCUM_WIDTH must be >= DOT_OUTPUT_WIDTH");
    end
    if (TREE_LATENCY < 1) begin : g_latency_check
      $fatal(1, "TREE_LATENCY must be >= 1");
    end
  endgenerate

  localparam logic [ACCUM_WIDTH-1:0] C_ACC_MAX = {1'b0, {(ACCUM_WIDTH-1){1'b1}}};
  localparam logic [ACCUM_WIDTH-1:0] C_ACC_MIN = {1'b1, {(ACCUM_WIDTH-1){1'b0}}};

  // Control delay line; first/last are masked by valid on entry so stray
  // markers never reach the accumulator.
  logic [TREE_LATENCY-1:0] r_v_dly, r_f_dly, r_l_dly;
  logic w_v_a, w_f_a, w_l_a;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_v_dly <= '0;
      r_f_dly <= '0;
      r_l_dly <= '0;
    end else begin
      r_v_dly[0] <= i_valid;
      r_f_dly[0] <= i_valid & i_first;
      r_l_dly[0] <= i_valid & i_last;
      for (int i = 1; i < TREE_LATENCY; i++) begin
        r_v_dly[i] <= r_v_dly[i-1];
        r_f_dly[i] <= r_f_dly[i-1];
        r_l_dly[i] <= r_l_dly[i-1];
      end
    end
  end

  assign w_v_a = r_v_dly[TREE_LATENCY-1];
  assign w_f_a = r_f_dly[TREE_LATENCY-1];
  assign w_l_a = r_l_dly[TREE_LATENCY-1];

  // Accumulate path
  logic [ACCUM_WIDTH-1:0] r_acc;
  logic [ACCUM_WIDTH-1:0] w_dot_ext;
  logic [ACCUM_WIDTH-1:0] w_sum;
  logic [ACCUM_WIDTH-1:0] w_add;
  logic [ACCUM_WIDTH-1:0] w_acc_next;

  assign w_dot_ext = ACCUM_WIDTH'($signed(i_dot));
  assign w_sum     = r_acc + w_dot_ext;

`ifdef PE_ACCUM_SAT_EN
  // Overflow only when both operands share a sign and the result flips it.
  logic w_ovf;
  logic r_sat;
  assign w_ovf = (r_acc[ACCUM_WIDTH-1] == w_dot_ext[ACCUM_WIDTH-1]) &&
                 (w_sum[ACCUM_WIDTH-1] != r_acc[ACCUM_WIDTH-1]);
  assign w_add = w_ovf ? (r_acc[ACCUM_WIDTH-1] ? C_ACC_MIN : C_ACC_MAX) : w_sum;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sat <= 1'b0;
    end else if (w_v_a && !w_f_a && w_ovf) begin
      r_sat <= 1'b1;
    end
  end
  assign o_sat = r_sat;
`else
  assign w_add = w_sum;
`endif

  assign w_acc_next = w_f_a ? w_dot_ext : w_add;

  logic r_in_group;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc      <= '0;
      r_in_group <= 1'b0;
    end else if (w_v_a) begin
      r_acc <= w_acc_next;
      if (w_l_a) begin
        r_in_group <= 1'b0;
      end else if (w_f_a) begin
        r_in_group <= 1'b1;
      end
    end
  end

  // Two-entry output buffer: r_head is what the consumer sees, r_tail is
  // only meaningful when r_count == 2.
  logic [ACCUM_WIDTH-1:0] r_head, r_tail;
  logic [1:0]             r_count;
  logic                   r_overflow;
  logic                   w_push, w_pop;

  assign w_push = w_v_a & w_l_a;
  assign w_pop  = (r_count != 2'd0) & i_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= 2'd0;
      r_overflow <= 1'b0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_push) begin
            r_head  <= w_acc_next;
            r_count <= 2'd1;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_head <= w_acc_next;
          end else if (w_push) begin
            r_tail  <= w_acc_next;
            r_count <= 2'd2;
          end else if (w_pop) begin
            r_count <= 2'd0;
          end
        end
        default: begin
          if (w_push && w_pop) begin
            r_head <= r_tail;
            r_tail <= w_acc_next;
          end else if (w_pop) begin
            r_head  <= r_tail;
            r_count <= 2'd1;
          end else if (w_push) begin
            r_overflow <= 1'b1;
          end
        end
      endcase
    end
  end

  assign o_valid    = (r_count != 2'd0);
  assign o_data     = r_head;
  assign o_full     = (r_count == 2'd2);
  assign o_in_group = r_in_group;
  assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pe_dot_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_dot_accumulator
// Purpose  : Directed self-checking bench for pe_dot_accumulator. Models the
//            adder-tree latency with a small dot pipeline so each i_dot
//            appears TREE_LATENCY cycles after its control.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_dot_accumulator;

  localparam int C_DW  = 24;
  localparam int C_AW  = 32;
  localparam int C_LAT = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            i_valid, i_first, i_last, i_ready;
  logic [C_DW-1:0] i_dot;
  logic            o_valid, o_full, o_in_group, o_overflow;
  logic [C_AW-1:0] o_data;
`ifdef PE_ACCUM_SAT_EN
  logic            o_sat;
`endif

  int checks = 0;
  int errors = 0;
  logic [C_DW-1:0] dpipe [C_LAT];
  logic            seen_valid;

  pe_dot_accumulator #(
    .DOT_OUTPUT_WIDTH(C_DW),
    .ACCUM_WIDTH     (C_AW),
    .TREE_LATENCY    (C_LAT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .i_valid   (i_valid),
    .i_first   (i_first),
    .i_last    (i_last),
    .i_dot     (i_dot),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .i_ready   (i_ready),
    .o_full    (o_full),
    .o_in_group(o_in_group),
`ifdef PE_ACCUM_SAT_EN
    .o_sat     (o_sat),
`endif
    .o_overflow(o_overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of tree-input control; i_dot comes out of the model
  // pipeline so it lines up with control issued C_LAT cycles earlier.
  // Returns 1 time unit after the clock edge that consumed the inputs.
  task automatic step(input logic v, input logic f, input logic l, input logic [C_DW-1:0] d);
    i_valid = v;
    i_first = f;
    i_last  = l;
    i_dot   = dpipe[C_LAT-1];
    for (int k = C_LAT-1; k > 0; k--) dpipe[k] = dpipe[k-1];
    dpipe[0] = d;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0;
    i_ready = 1'b1; i_dot = '0;
    for (int k = 0; k < C_LAT; k++) dpipe[k] = '0;
    @(posedge clock); #1;
    do_reset();

    // Reset state
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_full", o_full, 0);
    check("rst_in_group", o_in_group, 0);
    check("rst_overflow", o_overflow, 0);
`ifdef PE_ACCUM_SAT_EN
    check("rst_sat", o_sat, 0);
`endif

    // Group of 4: 10 - 3 + 7 + 100 = 114, o_valid at t_last+5
    step(1, 1, 0, 24'd10);
    step(1, 0, 0, -24'sd3);
    step(1, 0, 0, 24'd7);
    step(1, 0, 1, 24'd100);     // t_last; now at t+1
    idle(1);                    // t+2
    check("g4_in_group_open", o_in_group, 1);
    idle(2);                    // t+4
    check("g4_not_early", o_valid, 0);
    idle(1);                    // t+5
    check("g4_valid", o_valid, 1);
    check("g4_data", o_data, 114);
    check("g4_in_group_closed", o_in_group, 0);
    idle(1);
    check("g4_single_beat", o_valid, 0);

    // first & last on the same beat
    step(1, 1, 1, 24'hFFFFFB);
    idle(4);
    check("fl_valid", o_valid, 1);
    check("fl_data", o_data, 32'hFFFFFFFB);
    idle(1);

    // Wrap / saturation: 0xF0 + 256*0x7FFFFF = 0x7FFFFFF0, then + 0x20
    step(1, 1, 0, 24'h0000F0);
    for (int k = 0; k < 256; k++) step(1, 0, 0, 24'h7FFFFF);
    step(1, 0, 1, 24'h000020);
    idle(4);
    check("wrap_valid", o_valid, 1);
`ifdef PE_ACCUM_SAT_EN
    check("sat_data", o_data, 32'h7FFFFFFF);
    check("sat_flag", o_sat, 1);
`else
    check("wrap_data", o_data, 32'h80000010);
`endif
    idle(1);

    // Back-to-back groups {1,2},{3,4} with consumer stalled
    i_ready = 1'b0;
    step(1, 1, 0, 24'd1);
    step(1, 0, 1, 24'd2);
    step(1, 1, 0, 24'd3);
    step(1, 0, 1, 24'd4);
    idle(4);
    check("b2b_full", o_full, 1);
    check("b2b_head", o_data, 3);
    idle(1);
    check("b2b_head_stable", o_data, 3);

    // Third group while full, no pop -> dropped
    step(1, 1, 1, 24'd99);
    idle(4);
    check("ovf_flag", o_overflow, 1);
    check("ovf_full", o_full, 1);
    check("ovf_head", o_data, 3);
    i_ready = 1'b1;
    idle(1);
    check("drain_second", o_data, 7);
    check("drain_second_valid", o_valid, 1);
    idle(1);
    check("drain_empty", o_valid, 0);

    // Reset while a group is in flight through the tree
    step(1, 1, 1, 24'd55);      // t
    idle(1);                    // t+1
    reset = 1'b1;
    idle(1);                    // reset sampled at t+2
    reset = 1'b0;
    step(0, 1, 1, 24'd77);      // unqualified markers must be ignored
    seen_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idle(1);
      if (o_valid) seen_valid = 1'b1;
    end
    check("rstflight_no_valid", seen_valid, 0);
    check("rstflight_data", o_data, 0);
    check("rstflight_full", o_full, 0);
    check("rstflight_in_group", o_in_group, 0);
    check("rstflight_overflow", o_overflow, 0);

    // Full buffer, push coincides with pop -> no drop
    i_ready = 1'b0;
    step(1, 1, 1, 24'd10);      // a
    step(1, 1, 1, 24'd20);
    step(1, 1, 1, 24'd30);
    idle(3);                    // now at a+6, push of 30 in this cycle
    check("pp_full_before", o_full, 1);
    check("pp_head_before", o_data, 10);
    i_ready = 1'b1;
    idle(1);
    i_ready = 1'b0;
    check("pp_full_after", o_full, 1);
    check("pp_head_after", o_data, 20);
    check("pp_no_overflow", o_overflow, 0);
    i_ready = 1'b1;
    idle(1);
    check("pp_next_head", o_data, 30);
    idle(1);
    check("pp_empty", o_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
